// File: rtl/intrude_requester.sv
// intrude_requester: bus-initiator side of the intrusion handshake.
// Accepts one host read/write request at a time, drives RD or WR toward the
// intrusion controller with address/data held stable, waits for TRUDY, and
// returns read data plus completion status as a one-cycle RSP_VALID pulse.
//
// Optional build macro INTRUDE_TIMEOUT_EN: when defined, a STROBE that sees
// no TRUDY for TIMEOUT cycles is abandoned and completes with RSP_ERR=1 and
// RSP_RDATA all ones. When undefined, STROBE waits indefinitely and RSP_ERR
// is constant 0.
//
// Handshake: a host request transfers on a rising CLK edge where both
// REQ_VALID and REQ_READY are high; the host holds REQ_VALID and the request
// fields until that edge. RSP_VALID is a one-cycle pulse with no back-pressure;
// RSP_RDATA and RSP_ERR are meaningful only while it is high.
module intrude_requester #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESETL,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WR,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RD,
    output logic              WR,
    input  logic              TRUDY,
    output logic [ADDR_W-1:0] IADDR,
    output logic [DATA_W-1:0] IDOUT,
    input  logic [DATA_W-1:0] IDIN,
    output logic              BUSY,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_DONE   = 3'd3
    } state_t;

    state_t state;
    logic   wr_q;

    // The timeout limit must fit the 16-bit strobe counter.
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("intrude_requester: TIMEOUT must be in 1..65535");
    end

`ifdef INTRUDE_TIMEOUT_EN
    // Counter value on the last STROBE cycle allowed before giving up.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] strobe_cnt;
`else
    assign RSP_ERR = 1'b0;
`endif

    assign dbg_state = state;

    // Transaction sequencer: IDLE -> SETUP -> STROBE -> DONE -> IDLE, with
    // every host-facing and controller-facing output registered here.
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            state     <= S_IDLE;
            wr_q      <= 1'b0;
            REQ_READY <= 1'b1;
            BUSY      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RD        <= 1'b0;
            WR        <= 1'b0;
            IADDR     <= '0;
            IDOUT     <= '0;
`ifdef INTRUDE_TIMEOUT_EN
            strobe_cnt <= '0;
            RSP_ERR    <= 1'b0;
`endif
        end else begin
            // Completion is a single-cycle pulse.
            RSP_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID && REQ_READY) begin
                        wr_q      <= REQ_WR;
                        IADDR     <= REQ_ADDR;
                        IDOUT     <= REQ_WDATA;
                        BUSY      <= 1'b1;
                        REQ_READY <= 1'b0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Address/data have had a full cycle to settle; raise
                    // exactly one strobe on entry to STROBE.
                    RD    <= ~wr_q;
                    WR    <= wr_q;
                    state <= S_STROBE;
`ifdef INTRUDE_TIMEOUT_EN
                    strobe_cnt <= '0;
`endif
                end
                S_STROBE: begin
                    // TRUDY wins over a timeout landing in the same cycle.
                    if (TRUDY) begin
                        if (!wr_q) begin
                            RSP_RDATA <= IDIN;
                        end
                        RD        <= 1'b0;
                        WR        <= 1'b0;
                        RSP_VALID <= 1'b1;
                        state     <= S_DONE;
`ifdef INTRUDE_TIMEOUT_EN
                        RSP_ERR   <= 1'b0;
                    end else if (strobe_cnt == TIMEOUT_LAST) begin
                        RD        <= 1'b0;
                        WR        <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_RDATA <= '1;
                        RSP_ERR   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        strobe_cnt <= strobe_cnt + 16'd1;
`endif
                    end
                end
                S_DONE: begin
                    BUSY      <= 1'b0;
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    // Unused encodings recover to a clean idle.
                    RD        <= 1'b0;
                    WR        <= 1'b0;
                    BUSY      <= 1'b0;
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intrude_requester.sv
// tb_intrude_requester: directed, table-driven bench for intrude_requester.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_intrude_requester;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    logic              CLK;
    logic              RESETL;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WR;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;
    logic              RD;
    logic              WR;
    logic              TRUDY;
    logic [ADDR_W-1:0] IADDR;
    logic [DATA_W-1:0] IDOUT;
    logic [DATA_W-1:0] IDIN;
    logic              BUSY;
    logic [2:0]        dbg_state;

    intrude_requester #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(8)
    ) dut (
        .CLK      (CLK),
        .RESETL   (RESETL),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WR   (REQ_WR),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR  (RSP_ERR),
        .RD       (RD),
        .WR       (WR),
        .TRUDY    (TRUDY),
        .IADDR    (IADDR),
        .IDOUT    (IDOUT),
        .IDIN     (IDIN),
        .BUSY     (BUSY),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    // trudy_at: strobe cycle (1-based) on which TRUDY is raised, 0 = never.
    // trudy_tied: TRUDY held high for the whole transaction.
    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                trudy_at;
        logic              trudy_tied;
        logic [DATA_W-1:0] idin;
        int                exp_strobe;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_err;
    } vec_t;

    vec_t vecs[$];

    // ---------------- driver ----------------
    // Called and returns on a falling edge with the DUT idle.
    task automatic do_txn(input vec_t v, input string tag);
        int  strobe;
        int  lat;
        bit  got;
        bit  rd_seen;
        bit  wr_seen;
        bit  both;
        strobe = 0; lat = 0; got = 0; rd_seen = 0; wr_seen = 0; both = 0;

        chk({tag, "_ready_pre"}, 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b1;
        REQ_WR    = v.wr;
        REQ_ADDR  = v.addr;
        REQ_WDATA = v.wdata;
        IDIN      = v.idin;
        TRUDY     = v.trudy_tied;

        // Cycle N+1: SETUP.
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk({tag, "_busy"},   32'(BUSY), 32'd1);
        chk({tag, "_ready"},  32'(REQ_READY), 32'd0);
        chk({tag, "_iaddr"},  32'(IADDR), 32'(v.addr));
        chk({tag, "_idout"},  32'(IDOUT), 32'(v.wdata));
        chk({tag, "_setup_strobe"}, 32'({RD, WR}), 32'd0);

        for (int c = 1; c < 200; c++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                got = 1;
                lat = c;
                break;
            end
            if (RD) rd_seen = 1;
            if (WR) wr_seen = 1;
            if (RD && WR) both = 1;
            if (RD || WR) strobe++;
            TRUDY = v.trudy_tied || (v.trudy_at != 0 && strobe == v.trudy_at);
        end
        TRUDY = 1'b0;

        chk({tag, "_rsp_seen"},   32'(got), 32'd1);
        chk({tag, "_strobe_len"}, 32'(strobe), 32'(v.exp_strobe));
        chk({tag, "_rsp_lat"},    32'(lat), 32'(v.exp_strobe + 1));
        chk({tag, "_rdata"},      32'(RSP_RDATA), 32'(v.exp_rdata));
        chk({tag, "_err"},        32'(RSP_ERR), 32'(v.exp_err));
        chk({tag, "_done_strobe"}, 32'({RD, WR}), 32'd0);
        chk({tag, "_both_high"},  32'(both), 32'd0);
        chk({tag, "_wrong_strobe"}, 32'(v.wr ? rd_seen : wr_seen), 32'd0);

        // Back to idle one cycle after the pulse.
        @(negedge CLK);
        chk({tag, "_rsp_pulse"},  32'(RSP_VALID), 32'd0);
        chk({tag, "_ready_post"}, 32'(REQ_READY), 32'd1);
        chk({tag, "_busy_post"},  32'(BUSY), 32'd0);
    endtask

    // ---------------- test body ----------------
    initial begin
        logic [11:0] rd_h;
        logic [11:0] wr_h;
        logic [11:0] rv_h;
        int          acc_i[2];
        int          n_acc;
        logic [ADDR_W-1:0] iaddr_mid;
        bit          rsp_seen;
        bit          rd_up;

        vecs.push_back('{1'b0, 20'h4A123, 16'h0000, 4, 1'b0, 16'hBEEF, 4, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b1, 20'h00010, 16'h1234, 0, 1'b1, 16'h5555, 1, 16'hBEEF, 1'b0});
        vecs.push_back('{1'b0, 20'hFFFFF, 16'hA5A5, 1, 1'b0, 16'h0001, 1, 16'h0001, 1'b0});
        vecs.push_back('{1'b1, 20'h80000, 16'hFFFF, 2, 1'b0, 16'hAAAA, 2, 16'h0001, 1'b0});
        vecs.push_back('{1'b0, 20'h00000, 16'h0000, 3, 1'b0, 16'h0000, 3, 16'h0000, 1'b0});
`ifdef INTRUDE_TIMEOUT_EN
        vecs.push_back('{1'b0, 20'h12345, 16'h0000, 0, 1'b0, 16'h7777, 8, 16'hFFFF, 1'b1});
        vecs.push_back('{1'b0, 20'h23456, 16'h0000, 8, 1'b0, 16'h4321, 8, 16'h4321, 1'b0});
        vecs.push_back('{1'b1, 20'h34567, 16'h0F0F, 0, 1'b0, 16'h1111, 8, 16'hFFFF, 1'b1});
`endif

        RESETL    = 1'b0;
        REQ_VALID = 1'b0;
        REQ_WR    = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        TRUDY     = 1'b0;
        IDIN      = '0;

        // Reset values held for 3 cycles.
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        chk("rst_outs",  32'({RSP_VALID, RSP_ERR, RD, WR, BUSY}), 32'd0);
        chk("rst_iaddr", 32'(IADDR), 32'd0);
        chk("rst_idout", 32'(IDOUT), 32'd0);
        chk("rst_rdata", 32'(RSP_RDATA), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        RESETL = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", 32'(REQ_READY), 32'd1);
        chk("post_rst_busy",  32'(BUSY), 32'd0);

        // Table of single transactions.
        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: read then write, REQ_VALID held, TRUDY tied high.
        rd_h = '0; wr_h = '0; rv_h = '0; n_acc = 0; iaddr_mid = '0;
        acc_i[0] = -1; acc_i[1] = -1;
        TRUDY     = 1'b1;
        REQ_VALID = 1'b1;
        REQ_WR    = 1'b0;
        REQ_ADDR  = 20'h11111;
        REQ_WDATA = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            if (n_acc == 1) begin
                REQ_WR    = 1'b1;
                REQ_ADDR  = 20'h22222;
                REQ_WDATA = 16'h3C3C;
            end
            if (n_acc == 2) REQ_VALID = 1'b0;
            rd_h[i] = RD;
            wr_h[i] = WR;
            rv_h[i] = RSP_VALID;
            if (i == 5) iaddr_mid = IADDR;
            if (REQ_VALID && REQ_READY && n_acc < 2) begin
                acc_i[n_acc] = i;
                n_acc++;
            end
            @(negedge CLK);
        end
        TRUDY = 1'b0;
        chk("b2b_accepts",  32'(n_acc), 32'd2);
        chk("b2b_first",    32'(acc_i[0]), 32'd0);
        chk("b2b_spacing",  32'(acc_i[1] - acc_i[0]), 32'd4);
        chk("b2b_rd",       32'(rd_h), 32'h004);
        chk("b2b_wr",       32'(wr_h), 32'h040);
        chk("b2b_rsp",      32'(rv_h), 32'h088);
        chk("b2b_iaddr2",   32'(iaddr_mid), 32'h22222);

        // Reset while RD is high: strobe must drop immediately.
        REQ_VALID = 1'b1;
        REQ_WR    = 1'b0;
        REQ_ADDR  = 20'h0ABCD;
        TRUDY     = 1'b0;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        rd_up = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (RD) begin
                rd_up = 1;
                break;
            end
        end
        chk("mid_rd_up", 32'(rd_up), 32'd1);
        #2 RESETL = 1'b0;
        #1;
        chk("mid_rd_drop",  32'(RD), 32'd0);
        chk("mid_busy",     32'(BUSY), 32'd0);
        chk("mid_ready",    32'(REQ_READY), 32'd1);
        rsp_seen = 0;
        @(negedge CLK);
        rsp_seen |= RSP_VALID;
        RESETL = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            rsp_seen |= RSP_VALID;
        end
        chk("mid_no_rsp", 32'(rsp_seen), 32'd0);
        do_txn(vecs[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
